// File: rtl/tap_sched.sv
// tap_sched -- issue scheduler for a symmetric FIR with LANES complex multipliers.
//
// A pass walks the G coefficient groups in order, one group per cycle.
// hold inserts bubbles without losing the position in the pass. The
// first/last/valid tags of each issued group are delayed by PIPE_LAT cycles
// so that they line up with the multiplier outputs at the accumulator.
//
// Ports
//   Clk       rising-edge clock
//   Reset     synchronous, active-high reset; overrides every other input
//   empty     sample store holds no unprocessed sample
//   PushCoef  coefficient write this cycle; blocks the start of a new pass
//   hold      freeze group issue
//   grpSel    group index driving the sample/coef muxes
//   laneEn    per-lane enable for the issued group (0 when nothing is issued)
//   mulValid  the group on grpSel/laneEn is issued to the multipliers
//   first     issued group is group 0
//   last      issued group is group G-1
//   canShift  sample store may advance (same cycle as last)
//   accValid  multiplier results valid at the accumulator
//   accClr    accumulator loads instead of adding
//   accLast   final partial sum; accumulator pushes its result
//   busy      a pass is issuing or results are in flight
//   passCnt   completed passes, modulo 256
module tap_sched #(
    parameter int N_TAPS_HALF = 16,
    parameter int LANES       = 4,
    parameter int PIPE_LAT    = 4,
    localparam int G          = (N_TAPS_HALF + LANES - 1) / LANES,
    localparam int GW         = (G > 1) ? $clog2(G) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             empty,
    input  logic             PushCoef,
    input  logic             hold,
    output logic [GW-1:0]    grpSel,
    output logic [LANES-1:0] laneEn,
    output logic             mulValid,
    output logic             first,
    output logic             last,
    output logic             canShift,
    output logic             accValid,
    output logic             accClr,
    output logic             accLast,
    output logic             busy,
    output logic [7:0]       passCnt
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]       state, state_n;
    // nxt is the next group still to be issued in this pass; grpSel only
    // shows the most recently issued group, so hold can keep it steady.
    logic [GW-1:0]    nxt, nxt_n, issue_grp;
    logic             issue, is_first, is_last;
    logic [LANES-1:0] lane_n;

    // Stage 0 is the issue stage itself (mulValid/first/last); stage
    // PIPE_LAT lines up with the multiplier outputs.
    logic [PIPE_LAT:0] vld_pipe, fst_pipe, lst_pipe;

    always_comb begin
        state_n   = state;
        nxt_n     = nxt;
        issue     = 1'b0;
        issue_grp = nxt;
        case (state)
            IDLE: begin
                if (!empty && !hold && !PushCoef) begin
                    state_n   = ISSUE;
                    issue     = 1'b1;
                    issue_grp = '0;
                end
            end
            default: begin
                // The cycle showing group G-1 always ends the pass, which
                // forces one IDLE cycle between passes.
                if (last)
                    state_n = IDLE;
                else if (!hold)
                    issue = 1'b1;
            end
        endcase
        if (issue)
            nxt_n = issue_grp + GW'(1);
        is_first = issue && (issue_grp == '0);
        is_last  = issue && (int'(issue_grp) == G - 1);
        lane_n   = '0;
        for (int l = 0; l < LANES; l++)
            lane_n[l] = issue && ((int'(issue_grp) * LANES + l) < N_TAPS_HALF);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            nxt      <= '0;
            grpSel   <= '0;
            laneEn   <= '0;
            vld_pipe <= '0;
            fst_pipe <= '0;
            lst_pipe <= '0;
            busy     <= 1'b0;
            passCnt  <= '0;
        end else begin
            state    <= state_n;
            nxt      <= nxt_n;
            if (issue)
                grpSel <= issue_grp;
            laneEn   <= lane_n;
            vld_pipe <= {vld_pipe[PIPE_LAT-1:0], issue};
            fst_pipe <= {fst_pipe[PIPE_LAT-1:0], is_first};
            lst_pipe <= {lst_pipe[PIPE_LAT-1:0], is_last};
            // Next-cycle view: stages 1..PIPE_LAT take the current 0..PIPE_LAT-1.
            busy     <= (state_n == ISSUE) || (|vld_pipe[PIPE_LAT-1:0]);
            passCnt  <= passCnt + 8'(accLast);
        end
    end

    assign mulValid = vld_pipe[0];
    assign first    = fst_pipe[0];
    assign last     = lst_pipe[0];
    assign canShift = lst_pipe[0];
    assign accValid = vld_pipe[PIPE_LAT];
    assign accClr   = fst_pipe[PIPE_LAT];
    assign accLast  = lst_pipe[PIPE_LAT];

endmodule
